zeroriscy_multdiv_iter: RTL
===========================

// Module: zeroriscy_multdiv_iter
// PURPOSE
// Iterative multiply/divide unit for the EX stage; implements RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Owns no adder: drives the ALU's shared 33-bit adder through its multdiv operand inputs and consumes the ALU's extended sum.
// Fixed latency per operation; the ID stage holds the request stable and stalls until ready_o pulses.
// PARAMETERS
// none -- datapath fixed at 32 bits (ISA); localparam CALC_CYCLES = 32
// PORTS
// clk              in   1   clock, rising edge
// rst_n            in   1   asynchronous active-low reset
// mult_en_i        in   1   multiply request, held until ready_o
// div_en_i         in   1   divide request, held until ready_o (never high together with mult_en_i)
// operator_i       in   2   md_op_e: MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM
// signed_mode_i    in   2   [0]=op_a signed, [1]=op_b signed (DIV/REM: 2'b11 signed, 2'b00 unsigned)
// op_a_i           in   32  rs1 value
// op_b_i           in   32  rs2 value
// alu_adder_ext_i  in   34  ALU extended sum; [32:1]=sum, [33]=carry out
// alu_sel_o        out  1   selects multdiv operands into the ALU adder
// alu_operand_a_o  out  33  ALU adder operand a
// alu_operand_b_o  out  33  ALU adder operand b
// result_o         out  32  result, valid while ready_o=1
// ready_o          out  1   one-cycle completion pulse
// BEHAVIOUR
// - Adder convention: S = A + B + cin is requested as a={A,1'b1}, b={B,cin}; S=alu_adder_ext_i[32:1], cout=[33].
// - Reset: state=IDLE; ready_o, alu_sel_o=0; result_o, alu_operand_*_o, all datapath registers = 0.
// - Regs: hi[31:0], lo[31:0], bb[31:0] (|op_b|), sa, sb, neg, bzero, op.
// - FSM IDLE->ABS_A->ABS_B->CALC(x32)->FIX->DONE->IDLE; all states always traversed (fixed latency).
// - IDLE: on (mult_en_i|div_en_i): capture op; sa=signed_mode_i[0]&op_a_i[31]; sb=signed_mode_i[1]&op_b_i[31];
//   bzero=(op_b_i==0); hi=0; lo=op_a_i; bb=op_b_i. Capture edge = cycle 0.
// - ABS_A (cyc 1): if sa, lo=~lo+1 via adder (A=~lo,B=0,cin=1). ABS_B (cyc 2): same for bb if sb.
// - CALC mul (cyc 3..34): A=hi,B=bb,cin=0; if lo[0]: {hi,lo}={cout,S,lo[31:1]} else {hi,lo}={1'b0,hi,lo[31:1]}.
// - CALC div: s={hi,lo[31]} (33b); A=s[31:0],B=~bb,cin=1; ok=s[32]|cout;
//   hi = ok ? S : s[31:0]; lo={lo[30:0],ok}. After 32 steps lo=quotient, hi=remainder.
// - FIX (cyc 35), negation via adder only when required, else hold:
//   MULL: lo=-lo if sa^sb. MULH: hi=~hi+(lo==0) if sa^sb (uses pre-FIX lo).
//   DIV: lo=-lo if (sa^sb)&~bzero. REM: hi=-hi if sa.
// - DONE (cyc 36): ready_o=1, result_o = lo (MULL/DIV) or hi (MULH/REM); next state IDLE.
//   result_o is a register; it holds its last value after DONE.
// - alu_sel_o=1 in ABS_A, ABS_B, CALC, FIX; 0 in IDLE/DONE; alu_operand_*_o=0 when alu_sel_o=0.
// - Divide by zero falls out of the algorithm: quotient=0xFFFFFFFF, remainder=op_a (RISC-V semantics).
// - Signed overflow 0x80000000/-1: quotient 0x80000000, remainder 0, no special case.
// - Abort: en dropped in any non-IDLE state -> IDLE next edge, no ready_o, result_o unchanged.
// - New request seen in IDLE the cycle after DONE starts a new op; no back-to-back skip of IDLE.
// - Async reset mid-operation returns everything to reset values immediately.
// STRUCTURE
// - md_op_e (2-bit enum) belongs in zeroriscy_defines; FSM state typedef stays local.
// - Single module, no sub-module; adder is the ALU's (instantiated side by side in EX).
// - Bench wraps this block plus zeroriscy_alu with multdiv_en_i tied to alu_sel_o.
// TESTING
// - MULL 7 * 0xFFFFFFFD (mode 11) -> result 0xFFFFFFEB, ready_o at cycle 36 exactly, one cycle wide.
// - MULH 0x80000000*0x80000000 mode 11 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIVU 5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
// - Drop div_en_i at cycle 10 -> no ready_o, IDLE at cycle 11; new MULL 3*4 -> 12 after 36 more cycles.
// - Assert rst_n low at cycle 20 -> ready_o, alu_sel_o, result_o immediately 0; restart completes correctly.

Source files
------------

// File: rtl/zeroriscy_defines.sv
// ---------------------------------------------------------------------------
// zeroriscy_defines
// Shared definitions for the zeroriscy EX-stage blocks.
//   md_op_e       : multiply/divide operation selector driven by the ID stage
//   md_result_hi  : true when the operation returns the high/remainder word
// ---------------------------------------------------------------------------
package zeroriscy_defines;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  // MULH and REM deliver the hi register, MULL and DIV the lo register
  function automatic logic md_result_hi(md_op_e op);
    return (op == MD_OP_MULH) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/zeroriscy_multdiv_iter.sv
// ---------------------------------------------------------------------------
// zeroriscy_multdiv_iter
// Iterative RV32M multiply/divide unit. Uses the ALU's 33-bit adder instead
// of owning one; every operation takes the same number of cycles.
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   mult_en_i        multiply request, held until ready_o
//   div_en_i         divide request, held until ready_o
//   operator_i       md_op_e operation
//   signed_mode_i    [0] op_a signed, [1] op_b signed
//   op_a_i, op_b_i   rs1 / rs2 values
//   alu_adder_ext_i  ALU extended sum: [32:1] sum, [33] carry out
//   alu_sel_o        steers multdiv operands into the ALU adder
//   alu_operand_a_o  adder operand a = {A, 1'b1}
//   alu_operand_b_o  adder operand b = {B, cin}
//   result_o         result, valid while ready_o is high
//   ready_o          one-cycle completion pulse
//
// State table
//   state   | meaning
//   IDLE    | wait for request, capture operands
//   ABS_A   | lo = |op_a| when op_a is signed negative
//   ABS_B   | bb = |op_b| when op_b is signed negative
//   CALC    | 32 shift-add (mul) or restoring-subtract (div) steps
//   FIX     | sign correction of the selected result word
//   DONE    | ready_o high, result_o valid
// ---------------------------------------------------------------------------
module zeroriscy_multdiv_iter
  import zeroriscy_defines::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [33:0] alu_adder_ext_i,
  output logic        alu_sel_o,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic [31:0] result_o,
  output logic        ready_o
);

  localparam int         CALC_CYCLES = 32;
  localparam logic [4:0] CALC_LAST   = 5'(CALC_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ABS_A = 3'd1;
  localparam logic [2:0] S_ABS_B = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_FIX   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]  state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] lo, lo_nxt;
  logic [31:0] bb, bb_nxt;
  logic        sa, sa_nxt;
  logic        sb, sb_nxt;
  logic        neg, neg_nxt;
  logic        bzero, bzero_nxt;
  md_op_e      op, op_nxt;

  logic        en;
  logic [31:0] sum;
  logic        cout;
  logic [32:0] div_s;
  logic        div_ok;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic        fix_en, fix_hi, fix_cin;
  logic        finish;
  logic        unused_ext_lsb;

  assign en             = mult_en_i | div_en_i;
  assign sum            = alu_adder_ext_i[32:1];
  assign cout           = alu_adder_ext_i[33];
  // bit 0 only absorbs the carry-in trick and carries no information
  assign unused_ext_lsb = alu_adder_ext_i[0];

  // partial remainder is 33 bits: hi shifted left with the next dividend bit
  assign div_s  = {hi, lo[31]};
  assign div_ok = div_s[32] | cout;

  // sign correction plan for the FIX step
  always_comb begin
    fix_en  = 1'b0;
    fix_hi  = 1'b0;
    fix_cin = 1'b1;
    case (op)
      MD_OP_MULL: fix_en = neg;
      MD_OP_MULH: begin
        // -{hi,lo} upper word: borrow from lo only when lo is zero
        fix_en  = neg;
        fix_hi  = 1'b1;
        fix_cin = (lo == 32'h0);
      end
      MD_OP_DIV:  fix_en = neg & ~bzero;
      MD_OP_REM: begin
        fix_en = sa;
        fix_hi = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    bb_nxt    = bb;
    sa_nxt    = sa;
    sb_nxt    = sb;
    neg_nxt   = neg;
    bzero_nxt = bzero;
    op_nxt    = op;
    add_a     = 32'h0;
    add_b     = 32'h0;
    add_cin   = 1'b0;

    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_ABS_A;
          op_nxt    = md_op_e'(operator_i);
          sa_nxt    = signed_mode_i[0] & op_a_i[31];
          sb_nxt    = signed_mode_i[1] & op_b_i[31];
          neg_nxt   = (signed_mode_i[0] & op_a_i[31]) ^ (signed_mode_i[1] & op_b_i[31]);
          bzero_nxt = (op_b_i == 32'h0);
          hi_nxt    = 32'h0;
          lo_nxt    = op_a_i;
          bb_nxt    = op_b_i;
        end
      end

      S_ABS_A: begin
        add_a   = ~lo;
        add_cin = 1'b1;
        if (sa) lo_nxt = sum;
        state_nxt = S_ABS_B;
      end

      S_ABS_B: begin
        add_a   = ~bb;
        add_cin = 1'b1;
        if (sb) bb_nxt = sum;
        cnt_nxt   = CALC_LAST;
        state_nxt = S_CALC;
      end

      S_CALC: begin
        if (!op[1]) begin
          add_a = hi;
          add_b = bb;
          if (lo[0]) {hi_nxt, lo_nxt} = {cout, sum, lo[31:1]};
          else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[31:1]};
        end else begin
          add_a   = div_s[31:0];
          add_b   = ~bb;
          add_cin = 1'b1;
          hi_nxt  = div_ok ? sum : div_s[31:0];
          lo_nxt  = {lo[30:0], div_ok};
        end
        if (cnt == 5'd0) state_nxt = S_FIX;
        else             cnt_nxt   = cnt - 5'd1;
      end

      S_FIX: begin
        add_a   = fix_hi ? ~hi : ~lo;
        add_cin = fix_cin;
        if (fix_en) begin
          if (fix_hi) hi_nxt = sum;
          else        lo_nxt = sum;
        end
        state_nxt = S_DONE;
      end

      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // request withdrawn: abandon the operation without completing
    if ((state != S_IDLE) && !en) state_nxt = S_IDLE;
  end

  assign alu_sel_o       = (state == S_ABS_A) || (state == S_ABS_B) ||
                           (state == S_CALC)  || (state == S_FIX);
  assign alu_operand_a_o = alu_sel_o ? {add_a, 1'b1}   : 33'h0;
  assign alu_operand_b_o = alu_sel_o ? {add_b, add_cin} : 33'h0;

  // result is latched on the FIX edge so it is valid for the whole DONE cycle
  assign finish = (state == S_FIX) && en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      hi       <= 32'h0;
      lo       <= 32'h0;
      bb       <= 32'h0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      neg      <= 1'b0;
      bzero    <= 1'b0;
      op       <= MD_OP_MULL;
      ready_o  <= 1'b0;
      result_o <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      bb      <= bb_nxt;
      sa      <= sa_nxt;
      sb      <= sb_nxt;
      neg     <= neg_nxt;
      bzero   <= bzero_nxt;
      op      <= op_nxt;
      ready_o <= finish;
      if (finish) result_o <= md_result_hi(op) ? hi_nxt : lo_nxt;
    end
  end

endmodule
